// File: rtl/ni_rd_pipe.sv
`default_nettype none
// ============================================================================
// ni_rd_pipe : three-stage NI/RD code generator for the MRELBP feature path
// Rev 1.0
// ============================================================================
module ni_rd_pipe #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 8,
  parameter int FIXED = 24,
  parameter int P     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_mode,
  input  logic [WIDTH-1:0]   i_center,
  input  logic [P*FIXED-1:0] i_outer,
  input  logic [P*FIXED-1:0] i_inner,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [P-1:0]       o_ni,
  output logic [P-1:0]       o_rd,
  output logic [FIXED-1:0]   o_mean
);

  localparam int LOG2P = $clog2(P);
  localparam int SUMW  = FIXED + LOG2P;

  generate
    if ((P < 4) || (P > 32) || ((P & (P - 1)) != 0)) begin : g_bad_p
      $error("ni_rd_pipe: P must be a power of two in 4..32");
    end
    if (FIXED < WIDTH + FRAC) begin : g_bad_fixed
      $error("ni_rd_pipe: FIXED must be at least WIDTH+FRAC");
    end
  endgenerate

  logic               en;
  logic [FIXED-1:0]   center_fx;
  logic [FIXED-1:0]   mean;

  logic               s1_valid_q, s1_valid_d;
  logic [P*FIXED-1:0] s1_outer_q, s1_outer_d;
  logic [P*FIXED-1:0] s1_inner_q, s1_inner_d;

  logic               s2_valid_q, s2_valid_d;
  logic [P*FIXED-1:0] s2_outer_q, s2_outer_d;
  logic [SUMW-1:0]    s2_sum_q,   s2_sum_d;
  logic [P-1:0]       s2_rd_q,    s2_rd_d;

  logic               out_valid_q, out_valid_d;
  logic [P-1:0]       out_ni_q,    out_ni_d;
  logic [P-1:0]       out_rd_q,    out_rd_d;
  logic [FIXED-1:0]   out_mean_q,  out_mean_d;

  // One enable for every stage: the whole pipe advances or freezes together.
  assign en        = !out_valid_q || i_ready;
  assign o_ready   = en;
  assign center_fx = FIXED'(i_center) << FRAC;
  assign mean      = s2_sum_q[SUMW-1:LOG2P];

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_outer_d = s1_outer_q;
    s1_inner_d = s1_inner_q;
    if (en) begin
      s1_valid_d = i_valid;
      s1_outer_d = i_outer;
      s1_inner_d = i_mode ? i_inner : {P{center_fx}};
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_outer_d = s2_outer_q;
    s2_sum_d   = s2_sum_q;
    s2_rd_d    = s2_rd_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_outer_d = s1_outer_q;
      s2_sum_d   = '0;
      for (int k = 0; k < P; k++) begin
        s2_sum_d   = s2_sum_d + SUMW'(s1_outer_q[k*FIXED +: FIXED]);
        s2_rd_d[k] = (s1_outer_q[k*FIXED +: FIXED] >= s1_inner_q[k*FIXED +: FIXED]);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_ni_d    = out_ni_q;
    out_rd_d    = out_rd_q;
    out_mean_d  = out_mean_q;
    if (en) begin
      out_valid_d = s2_valid_q;
      out_rd_d    = s2_rd_q;
      out_mean_d  = mean;
      for (int k = 0; k < P; k++) begin
        out_ni_d[k] = (s2_outer_q[k*FIXED +: FIXED] >= mean);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_outer_q  <= '0;
      s1_inner_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_outer_q  <= '0;
      s2_sum_q    <= '0;
      s2_rd_q     <= '0;
      out_valid_q <= 1'b0;
      out_ni_q    <= '0;
      out_rd_q    <= '0;
      out_mean_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_outer_q  <= s1_outer_d;
      s1_inner_q  <= s1_inner_d;
      s2_valid_q  <= s2_valid_d;
      s2_outer_q  <= s2_outer_d;
      s2_sum_q    <= s2_sum_d;
      s2_rd_q     <= s2_rd_d;
      out_valid_q <= out_valid_d;
      out_ni_q    <= out_ni_d;
      out_rd_q    <= out_rd_d;
      out_mean_q  <= out_mean_d;
    end
  end

  assign o_valid = out_valid_q;
  assign o_ni    = out_ni_q;
  assign o_rd    = out_rd_q;
  assign o_mean  = out_mean_q;

endmodule
`default_nettype wire

// File: tb/tb_ni_rd_pipe.sv
`default_nettype none
// ============================================================================
// tb_ni_rd_pipe : directed + randomized bench for ni_rd_pipe with a scoreboard
// Rev 1.0
// ============================================================================
module tb_ni_rd_pipe;

  localparam int W  = 8;
  localparam int FR = 8;
  localparam int FX = 24;
  localparam int P  = 8;

  typedef struct {
    logic [P-1:0]  ni;
    logic [P-1:0]  rd;
    logic [FX-1:0] mean;
    int            acc_cyc;
    bit            chk_lat;
  } exp_t;

  logic            clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic            i_mode = 1'b0;
  logic [W-1:0]    i_center = '0;
  logic [P*FX-1:0] i_outer = '0;
  logic [P*FX-1:0] i_inner = '0;
  logic            o_valid;
  logic            i_ready = 1'b1;
  logic [P-1:0]    o_ni;
  logic [P-1:0]    o_rd;
  logic [FX-1:0]   o_mean;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_out = 0;
  bit   lat_chk = 1'b0;
  bit   stall_arm = 1'b0;
  bit   rand_ready = 1'b0;
  exp_t exp_q[$];

  logic [P-1:0]  last_ni, last_rd, prev_rd;
  logic [FX-1:0] last_mean;
  bit            had_stall = 1'b0;
  logic [P-1:0]  hold_ni, hold_rd;
  logic [FX-1:0] hold_mean;

  ni_rd_pipe #(.WIDTH(W), .FRAC(FR), .FIXED(FX), .P(P)) dut (
    .i_clk    (clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_mode   (i_mode),
    .i_center (i_center),
    .i_outer  (i_outer),
    .i_inner  (i_inner),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_ni     (o_ni),
    .o_rd     (o_rd),
    .o_mean   (o_mean)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer mean by division, thresholds by plain comparison.
  function automatic exp_t model(input logic m, input logic [W-1:0] c,
                                 input logic [P*FX-1:0] out, input logic [P*FX-1:0] inn);
    exp_t e;
    longint unsigned sum = 0;
    longint unsigned mval, ov, rv;
    for (int k = 0; k < P; k++) sum += longint'(out[k*FX +: FX]);
    mval = sum / P;
    for (int k = 0; k < P; k++) begin
      ov = longint'(out[k*FX +: FX]);
      rv = m ? longint'(inn[k*FX +: FX]) : longint'(c) * 256;
      e.ni[k] = (ov >= mval);
      e.rd[k] = (ov >= rv);
    end
    e.mean    = FX'(mval);
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  function automatic logic [P*FX-1:0] fill(input logic [FX-1:0] v);
    logic [P*FX-1:0] r;
    for (int k = 0; k < P; k++) r[k*FX +: FX] = v;
    return r;
  endfunction

  function automatic logic [P*FX-1:0] rand_ring();
    logic [P*FX-1:0] r;
    for (int k = 0; k < P; k++)
      r[k*FX +: FX] = FX'(($urandom_range(30, 60) << 8) | $urandom_range(0, 255));
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic m, input logic [W-1:0] c,
                      input logic [P*FX-1:0] out, input logic [P*FX-1:0] inn);
    exp_t e;
    int   n = 0;
    i_valid = 1'b1; i_mode = m; i_center = c; i_outer = out; i_inner = inn;
    e = model(m, c, out, inn);
    forever begin
      #1;
      if (o_ready) begin
        e.acc_cyc = cyc;
        e.chk_lat = lat_chk;
        exp_q.push_back(e);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      n++;
      if (n > 200) begin
        check("send_accept_timeout", 64'(o_ready), 64'd1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    i_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // Sink: fixed 4-cycle stall on request, else optional random backpressure.
  always @(negedge clk) begin
    if (stall_arm && o_valid) begin
      stall_arm = 1'b0;
      i_ready   = 1'b0;
      repeat (4) @(negedge clk);
      i_ready   = 1'b1;
    end else begin
      i_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: scoreboard, latency and hold-during-stall checks.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (i_rst_n) begin
      if (had_stall) begin
        check("stall_hold_valid", 64'(o_valid), 64'd1);
        check("stall_hold_ni",    64'(o_ni),    64'(hold_ni));
        check("stall_hold_rd",    64'(o_rd),    64'(hold_rd));
        check("stall_hold_mean",  64'(o_mean),  64'(hold_mean));
      end
      if (o_valid && !i_ready) check("o_ready_in_stall", 64'(o_ready), 64'd0);
      had_stall = o_valid && !i_ready;
      hold_ni = o_ni; hold_rd = o_rd; hold_mean = o_mean;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(o_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_ni",   64'(o_ni),   64'(e.ni));
          check("sb_rd",   64'(o_rd),   64'(e.rd));
          check("sb_mean", 64'(o_mean), 64'(e.mean));
          if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'd3);
        end
        prev_rd   = last_rd;
        last_ni   = o_ni;
        last_rd   = o_rd;
        last_mean = o_mean;
        n_out++;
      end
    end else begin
      had_stall = 1'b0;
    end
  end

  initial begin
    logic [P*FX-1:0] ro, ri;
    int base;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_ni",    64'(o_ni),    64'd0);
    check("rst_o_rd",    64'(o_rd),    64'd0);
    check("rst_o_mean",  64'(o_mean),  64'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    #1;
    check("rst_o_ready", 64'(o_ready), 64'd1);
    @(negedge clk);

    // 1: ramp outer ring vs centre 45
    lat_chk = 1'b1;
    for (int k = 0; k < P; k++) ro[k*FX +: FX] = FX'((k + 1) * 10) << 8;
    send(1'b0, 8'd45, ro, '0);
    drain();
    check("t1_mean", 64'(last_mean), 64'h002D00);
    check("t1_ni",   64'(last_ni),   64'hF0);
    check("t1_rd",   64'(last_rd),   64'hF0);

    // 2: equality and truncation
    send(1'b0, 8'd100, fill(24'h006400), '0);
    drain();
    check("t2a_mean", 64'(last_mean), 64'h006400);
    check("t2a_ni",   64'(last_ni),   64'hFF);
    check("t2a_rd",   64'(last_rd),   64'hFF);
    ro = '0;
    ro[FX-1:0] = 24'h000001;
    send(1'b0, 8'd0, ro, '0);
    drain();
    check("t2b_mean", 64'(last_mean), 64'h0);
    check("t2b_ni",   64'(last_ni),   64'hFF);
    check("t2b_rd",   64'(last_rd),   64'hFF);

    // 3: inner-ring mode, then centre mode back-to-back with same inner ring
    for (int k = 0; k < P; k++) ri[k*FX +: FX] = (k % 2 == 0) ? 24'h003100 : 24'h003300;
    send(1'b1, 8'd0,  fill(24'h003200), ri);
    send(1'b0, 8'd49, fill(24'h003200), ri);
    drain();
    check("t3_rd_inner",  64'(prev_rd), 64'h55);
    check("t3_ni",        64'(last_ni), 64'hFF);
    check("t3_rd_centre", 64'(last_rd), 64'hFF);

    // 6: maximum values
    send(1'b1, 8'hFF, fill(24'hFFFFFF), fill(24'hFFFFFF));
    drain();
    check("t6_mean", 64'(last_mean), 64'hFFFFFF);
    check("t6_ni",   64'(last_ni),   64'hFF);
    check("t6_rd",   64'(last_rd),   64'hFF);

    // 4: six distinct sets streamed with a 4-cycle stall
    lat_chk   = 1'b0;
    base      = n_out;
    stall_arm = 1'b1;
    for (int s = 0; s < 6; s++)
      send(1'($urandom_range(0, 1)), 8'(35 + s * 3), rand_ring(), rand_ring());
    drain();
    check("t4_count", 64'(n_out - base), 64'd6);

    // 5: reset with two sets in flight
    send(1'b0, 8'd40, rand_ring(), '0);
    send(1'b1, 8'd40, rand_ring(), rand_ring());
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    i_rst_n = 1'b1;
    #1;
    check("t5_o_valid", 64'(o_valid), 64'd0);
    check("t5_o_ni",    64'(o_ni),    64'd0);
    check("t5_o_rd",    64'(o_rd),    64'd0);
    check("t5_o_mean",  64'(o_mean),  64'd0);
    check("t5_o_ready", 64'(o_ready), 64'd1);
    @(negedge clk);
    base = n_out;
    idle(6);
    check("t5_no_stale", 64'(n_out - base), 64'd0);
    lat_chk = 1'b1;
    send(1'b0, 8'd50, rand_ring(), '0);
    drain();
    check("t5_after_count", 64'(n_out - base), 64'd1);

    // Randomized traffic with random backpressure and gaps
    lat_chk    = 1'b0;
    rand_ready = 1'b1;
    base       = n_out;
    for (int s = 0; s < 60; s++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom_range(30, 60)), rand_ring(), rand_ring());
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_ready = 1'b0;
    drain();
    check("rand_count", 64'(n_out - base), 64'd60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/ni_rd_pipe.md
Name: ni_rd_pipe

Overview:
Pipelined, parametrised NI/RD code generator for the MRELBP feature path. It accepts P outer-ring samples plus either an inner ring or the centre pixel, all in unsigned fixed point. It produces the P-bit neighbour-intensity (NI) code and the P-bit radial-difference (RD) code. It generalises the fixed R=2, 8-point combinational calculator to any power-of-two point count, adds a selectable inner-ring source, and adds a valid/ready streaming interface with backpressure.

Parameters:
WIDTH, 8, pixel width in bits
FRAC, 8, fractional bits of a fixed-point sample
FIXED, 24, fixed-point sample width; must be at least WIDTH+FRAC; integer pixel p maps to p<<FRAC
P, 8, sampling points per ring; power of two, 4..32

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_valid  in  1  input sample set valid
o_ready  out  1  block can accept input this cycle
i_mode  in  1  0: inner reference = centre pixel; 1: inner reference = i_inner ring
i_center  in  WIDTH  centre pixel (integer)
i_outer  in  P*FIXED  outer ring; point k at bits [k*FIXED +: FIXED]
i_inner  in  P*FIXED  inner ring, same packing; ignored when i_mode=0
o_valid  out  1  output valid
i_ready  in  1  downstream accepts output
o_ni  out  P  NI code; bit k for point k
o_rd  out  P  RD code; bit k for point k
o_mean  out  FIXED  outer-ring mean used for NI (debug/verification)

Behaviour:
- Reset: synchronous, active-low; the clock is the single i_clk. When i_rst_n=0 at a rising edge, all stage valids, o_valid, o_ni, o_rd and o_mean clear to 0; in-flight data is dropped. o_ready=1 in the cycle after reset is released.
- Handshake: global pipeline enable en = !o_valid || i_ready; o_ready = en.
  - Input accepted on an edge with i_valid && o_ready.
  - Output consumed on an edge with o_valid && i_ready.
  - While o_valid && !i_ready: o_ni, o_rd and o_mean hold stable, every stage holds, and nothing is lost or duplicated. Order is preserved.
- Latency: 3 cycles from the accepting edge to o_valid=1 when there are no stalls. Throughput is 1 set per cycle.
- Stage 1 (capture): register i_outer and the inner reference. When i_mode=0, inner_k = {0, i_center, FRAC zeros}, zero-extended to FIXED, for all k. When i_mode=1, inner_k = i_inner[k]. Mode is sampled per input set and travels with it.
- Stage 2 (sum/diff):
  - sum = sum of all outer_k, width FIXED+log2(P); no overflow is possible.
  - rd_k = (outer_k >= inner_k), unsigned.
- Stage 3 (mean/NI):
  - mean = sum >> log2(P), truncating (floor).
  - ni_k = (outer_k >= mean), unsigned; equality gives 1.
  - Register o_ni, o_rd and o_mean.
- Pipeline bubbles (invalid stages) may carry stale data, but o_* are only meaningful when o_valid=1. Registers update only when en=1.
- Illegal parameters (P not a power of two, FIXED < WIDTH+FRAC) stop elaboration with $error.

Test Plan (P=8, FRAC=8, FIXED=24, fixed value v means v<<8):
1. Single set, i_mode=0:
   - Stimulus: outer = 10,20,...,80 for k=0..7; centre = 45.
   - Response: o_valid 3 cycles after accept; o_mean = 0x002D00; o_ni = 8'hF0; o_rd = 8'hF0.
2. Equality and truncation:
   - All outer = 100, centre = 100 -> o_ni = 8'hFF, o_rd = 8'hFF, o_mean = 0x006400.
   - Outer k0 = 24'h000001, others 0, centre = 0 -> o_mean = 0, o_ni = 8'hFF, o_rd = 8'hFF.
3. Inner-ring mode, i_mode=1:
   - Stimulus: outer all 0x003200; inner = 0x003100 for even k, 0x003300 for odd k.
   - Response: o_rd = 8'h55, o_ni = 8'hFF.
   - A next set with i_mode=0 accepted back-to-back uses the centre pixel; the mode is verified to be per-set.
4. Backpressure:
   - Stimulus: stream 6 distinct sets back-to-back; hold i_ready=0 for 4 cycles once o_valid rises.
   - Response: o_ready=0 during the stall; outputs stable; all 6 results emerge in order, none lost or duplicated; scoreboard matches a reference model.
5. Reset mid-operation:
   - Stimulus: 2 sets in flight; i_rst_n=0 for one edge.
   - Response: next cycle o_valid=0 and o_ni = o_rd = o_mean = 0; neither in-flight set ever appears; a new set afterwards returns with 3-cycle latency.
6. Maximum values:
   - Stimulus: all outer = 24'hFFFFFF; inner (mode 1) = 24'hFFFFFF.
   - Response: o_mean = 24'hFFFFFF (no sum overflow); o_ni = 8'hFF; o_rd = 8'hFF.
